fsm_seq_ctrl: RTL and testbench
===============================

# fsm_seq_ctrl

Parametrised start/load/process/done sequencer. It is the next generation of the fixed three-state control FSM. It adds configurable LOAD and PROCESS durations, selectable state encoding (one-hot or Gray), a done/acknowledge handshake, abort, and a completed-run counter. It sits between a block-level command source and a datapath that needs timed load and process enables.

## Interface
Parameters:
- `LOAD_CYCLES`, default 1: cycles spent in LOAD; legal range ≥1.
- `PROC_CYCLES`, default 4: cycles spent in PROCESS; legal range ≥1.
- `ONE_HOT`, default 1: state register encoding. 1 = one-hot, 4 bits. 0 = Gray, 2 bits (IDLE=00, LOAD=01, PROCESS=11, DONE=10).
- `RUN_W`, default 16: width of the completed-run counter.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: request a run. Sampled only in IDLE.
- `abort` in 1: cancel the current run. Effective only in LOAD or PROCESS.
- `done_ack` in 1: acknowledges completion. Effective only in DONE.
- `load_en` out 1: high for every cycle in LOAD.
- `proc_en` out 1: high for every cycle in PROCESS.
- `busy` out 1: equals `load_en | proc_en`.
- `done` out 1: high for every cycle in DONE.
- `state_oh` out 4: decoded state as {DONE, PROCESS, LOAD, IDLE}. Always one-hot, whatever the encoding.
- `run_cnt` out RUN_W: number of completed runs. Wraps to 0.
- `err` out 1: sticky illegal-state flag. See Configuration.

## Operation
- States: IDLE, LOAD, PROCESS, DONE. All outputs are Moore outputs, decoded from registered state.
- IDLE:
  - `start`=1 → LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - The phase timer loads `LOAD_CYCLES-1` on entry and decrements each cycle.
  - At 0 → PROCESS. The timer then loads `PROC_CYCLES-1`.
- PROCESS:
  - At timer 0 → DONE.
  - `run_cnt` increments by 1 on the transition into DONE. It is modulo 2^RUN_W.
- DONE:
  - `done_ack`=1 → IDLE.
  - Otherwise hold in DONE indefinitely.
- `abort`=1 in LOAD or PROCESS → IDLE on the next edge.
  - `abort` has priority over timer expiry.
  - An aborted run does not increment `run_cnt`.
- Ignored inputs:
  - `abort` is ignored in IDLE and DONE.
  - `start` is ignored outside IDLE.
  - `done_ack` is ignored outside DONE.
- `start` and `done_ack` high together in DONE → IDLE. `start` is not captured, so a new run needs `start` again in IDLE.
- Reset values:
  - state = IDLE, so `state_oh`=4'b0001.
  - `load_en`=`proc_en`=`busy`=`done`=0.
  - `run_cnt`=0, `err`=0, timer=0.
- Reset asserted mid-run returns the block to IDLE on the next edge, with all of the reset values above.
- Phase timer width: `$clog2(max(LOAD_CYCLES,PROC_CYCLES))`, minimum 1 bit.
- Illegal state encodings (one-hot with ≠1 bit set) always recover to IDLE on the next edge.

## Timing
- `start` sampled high at edge 0:
  - LOAD during cycles 1..L (L = `LOAD_CYCLES`).
  - PROCESS during cycles L+1..L+P (P = `PROC_CYCLES`).
  - `done`=1 from cycle L+P+1.
- Latency from `start` to `done` is L+P+1 cycles.
- `done_ack` sampled high at edge k → `done`=0 and IDLE from cycle k+1. The earliest next `start` is sampled at edge k+1.
- Minimum start-to-start period is L+P+2 cycles, reached with `done_ack` tied high.

## Configuration
- Macro: `FSM_ILLEGAL_STATE_DETECT_EN`.
- Defined:
  - `err` sets on any cycle in which the state register holds an illegal encoding.
  - `err` stays high until `rst`.
  - Recovery to IDLE still occurs.
  - With `ONE_HOT`=0 every code is legal, so `err` stays 0.
- Undefined:
  - `err` is tied to 0.
  - Recovery to IDLE is unchanged.

## Structure
- Package `fsm_seq_pkg` holds:
  - the state index enum (IDLE, LOAD, PROCESS, DONE);
  - the Gray encoding constants;
  - the one-hot bit positions;
  - a function mapping the encoded state to `state_oh`.
- Sub-module `fsm_seq_timer` is a loadable down-counter with a zero flag. It is parametrised by width and instantiated once.

## Test plan
- L=1, P=4, ONE_HOT=1: `start` pulse at cycle 0 → `load_en` in cycle 1, `proc_en` in cycles 2–5, `done` from cycle 6. `done_ack` at cycle 8 → IDLE at cycle 9, `run_cnt`=1.
- L=3, P=2, ONE_HOT=0: `state_oh` sequence is 0001, 0010×3, 0100×2, 1000. `abort` in the second PROCESS cycle → IDLE next cycle, `run_cnt` unchanged.
- `start` and `done_ack` held high continuously with L=1, P=1 → runs repeat every 4 cycles. `run_cnt` wraps 0xFFFF→0x0000 (RUN_W=16, preloaded via 65535 runs or forced).
- `rst` asserted during PROCESS → next cycle: all outputs at reset values, `state_oh`=0001, timer=0.
- Macro defined, ONE_HOT=1: force state to 4'b0110 → `err`=1 and IDLE next cycle; `err` stays 1 until `rst`. Same test without the macro → `err`=0.
- `start` pulsed during LOAD and in DONE together with `abort` → both ignored. Sequence and `done` timing are unchanged.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared types, encodings and decode helpers for the
// start/load/process/done sequencer.
package fsm_seq_pkg;

    // Logical state index; also the bit position within state_oh.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StProc = 2'd2,
        StDone = 2'd3
    } state_idx_e;

    // Gray encoding: adjacent states in the run sequence differ by one bit.
    localparam logic [1:0] GrayIdle = 2'b00;
    localparam logic [1:0] GrayLoad = 2'b01;
    localparam logic [1:0] GrayProc = 2'b11;
    localparam logic [1:0] GrayDone = 2'b10;

    // One-hot bit positions, ordered {DONE, PROCESS, LOAD, IDLE}.
    localparam int unsigned OhIdleBit = 0;
    localparam int unsigned OhLoadBit = 1;
    localparam int unsigned OhProcBit = 2;
    localparam int unsigned OhDoneBit = 3;

    // True when exactly one bit of a one-hot code is set.
    function automatic logic oh_legal(input logic [3:0] enc);
        return (enc != 4'b0000) && ((enc & (enc - 4'd1)) == 4'b0000);
    endfunction

    // Logical state to its one-hot decode.
    function automatic logic [3:0] idx_to_oh(input state_idx_e s);
        return 4'b0001 << s;
    endfunction

    // Logical state to the register encoding (Gray codes sit in bits [1:0]).
    function automatic logic [3:0] encode_state(input state_idx_e s, input logic one_hot);
        logic [3:0] enc;
        enc = 4'b0000;
        if (one_hot) begin
            enc = idx_to_oh(s);
        end else begin
            case (s)
                StIdle:  enc = {2'b00, GrayIdle};
                StLoad:  enc = {2'b00, GrayLoad};
                StProc:  enc = {2'b00, GrayProc};
                default: enc = {2'b00, GrayDone};
            endcase
        end
        return enc;
    endfunction

    // Encoded state to state_oh; an illegal one-hot code decodes as IDLE so
    // the decode is always one-hot.
    function automatic logic [3:0] state_to_oh(input logic [3:0] enc, input logic one_hot);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[OhIdleBit] = 1'b1;
        if (one_hot) begin
            if (oh_legal(enc)) begin
                oh = enc;
            end
        end else begin
            oh = 4'b0000;
            case (enc[1:0])
                GrayIdle: oh[OhIdleBit] = 1'b1;
                GrayLoad: oh[OhLoadBit] = 1'b1;
                GrayProc: oh[OhProcBit] = 1'b1;
                default:  oh[OhDoneBit] = 1'b1;
            endcase
        end
        return oh;
    endfunction

    // One-hot decode back to the logical state index.
    function automatic state_idx_e oh_to_idx(input logic [3:0] oh);
        state_idx_e s;
        s = StIdle;
        if (oh[OhLoadBit]) begin
            s = StLoad;
        end else if (oh[OhProcBit]) begin
            s = StProc;
        end else if (oh[OhDoneBit]) begin
            s = StDone;
        end
        return s;
    endfunction

endpackage

// File: rtl/fsm_seq_timer.sv
// fsm_seq_timer: loadable down-counter with a zero flag. Load wins over
// decrement; the count saturates at zero.
module fsm_seq_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    // Phase counter: synchronous clear, load on phase entry, else count down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: parametrised start/load/process/done sequencer with
// timed LOAD/PROCESS phases, done/ack handshake, abort and a run counter.
// Optional feature macro: FSM_ILLEGAL_STATE_DETECT_EN (sticky err flag on
// an illegal one-hot state code). Without it err is tied low.
module fsm_seq_ctrl
    import fsm_seq_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = 1,
    parameter int unsigned PROC_CYCLES = 4,
    parameter int unsigned ONE_HOT     = 1,
    parameter int unsigned RUN_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             done_ack,
    output logic             load_en,
    output logic             proc_en,
    output logic             busy,
    output logic             done,
    output logic [3:0]       state_oh,
    output logic [RUN_W-1:0] run_cnt,
    output logic             err
);

    localparam int unsigned MaxCycles = (LOAD_CYCLES > PROC_CYCLES) ? LOAD_CYCLES : PROC_CYCLES;
    localparam int unsigned TW        = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam int unsigned SW        = (ONE_HOT != 0) ? 4 : 2;
    localparam logic        OneHot    = (ONE_HOT != 0);

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [TW-1:0] LoadInit = TW'(LOAD_CYCLES - 1);
    localparam logic [TW-1:0] ProcInit = TW'(PROC_CYCLES - 1);

    logic [SW-1:0]    state_q;
    logic [3:0]       state_enc;
    logic [3:0]       cur_oh;
    logic             legal;
    state_idx_e       cur;
    state_idx_e       nxt;

    logic             load_en_q;
    logic             proc_en_q;
    logic             done_q;
    logic [3:0]       state_oh_q;
    logic [RUN_W-1:0] run_cnt_q;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;
    logic             run_inc;

    // Decode the state register into a logical state.
    always_comb begin
        state_enc = 4'(state_q);
        legal     = OneHot ? oh_legal(state_enc) : 1'b1;
        cur_oh    = state_to_oh(state_enc, OneHot);
        cur       = oh_to_idx(cur_oh);
    end

    // Next-state and phase-timer control; abort outranks timer expiry.
    always_comb begin
        nxt      = cur;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        run_inc  = 1'b0;
        unique case (cur)
            StIdle: begin
                if (start) begin
                    nxt      = StLoad;
                    tmr_load = 1'b1;
                    tmr_val  = LoadInit;
                end
            end
            StLoad: begin
                if (abort) begin
                    nxt = StIdle;
                end else if (tmr_zero) begin
                    nxt      = StProc;
                    tmr_load = 1'b1;
                    tmr_val  = ProcInit;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StProc: begin
                if (abort) begin
                    nxt = StIdle;
                end else if (tmr_zero) begin
                    nxt     = StDone;
                    run_inc = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StDone: begin
                if (done_ack) begin
                    nxt = StIdle;
                end
            end
            default: nxt = StIdle;
        endcase
        // A corrupted one-hot code always falls back to IDLE.
        if (!legal) begin
            nxt      = StIdle;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
            run_inc  = 1'b0;
        end
    end

    // State register with registered Moore outputs and the run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SW'(encode_state(StIdle, OneHot));
            load_en_q  <= 1'b0;
            proc_en_q  <= 1'b0;
            done_q     <= 1'b0;
            state_oh_q <= idx_to_oh(StIdle);
            run_cnt_q  <= '0;
        end else begin
            state_q    <= SW'(encode_state(nxt, OneHot));
            load_en_q  <= (nxt == StLoad);
            proc_en_q  <= (nxt == StProc);
            done_q     <= (nxt == StDone);
            state_oh_q <= idx_to_oh(nxt);
            if (run_inc) begin
                run_cnt_q <= run_cnt_q + RUN_W'(1);
            end
        end
    end

`ifdef FSM_ILLEGAL_STATE_DETECT_EN
    logic err_q;

    // Sticky flag: any cycle holding an illegal code sets it until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (!legal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    fsm_seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign load_en  = load_en_q;
    assign proc_en  = proc_en_q;
    assign busy     = load_en_q | proc_en_q;
    assign done     = done_q;
    assign state_oh = state_oh_q;
    assign run_cnt  = run_cnt_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl: three sequencer instances (L1/P4 one-hot, L3/P2 Gray,
// L1/P1 one-hot) checked every cycle against a run-timeline model.
module tb_fsm_seq_ctrl;

`ifdef FSM_ILLEGAL_STATE_DETECT_EN
    localparam bit DetectEn = 1'b1;
`else
    localparam bit DetectEn = 1'b0;
`endif

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MDone = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v, start_v, abort_v, ack_v;
    logic [2:0]  load_v, proc_v, busy_v, done_v, err_v;
    logic [3:0]  oh_v [3];
    logic [15:0] rc_v [3];

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode, cycle number within the run (1..L+P), runs, err, forced-illegal.
    int m_mode [3];
    int m_el   [3];
    int m_runs [3];
    bit m_err  [3];
    bit m_ill  [3];

    fsm_seq_ctrl #(.LOAD_CYCLES(1), .PROC_CYCLES(4), .ONE_HOT(1), .RUN_W(16)) dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
        .done_ack(ack_v[0]), .load_en(load_v[0]), .proc_en(proc_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .state_oh(oh_v[0]), .run_cnt(rc_v[0]), .err(err_v[0])
    );

    fsm_seq_ctrl #(.LOAD_CYCLES(3), .PROC_CYCLES(2), .ONE_HOT(0), .RUN_W(16)) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
        .done_ack(ack_v[1]), .load_en(load_v[1]), .proc_en(proc_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .state_oh(oh_v[1]), .run_cnt(rc_v[1]), .err(err_v[1])
    );

    fsm_seq_ctrl #(.LOAD_CYCLES(1), .PROC_CYCLES(1), .ONE_HOT(1), .RUN_W(16)) dut2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .abort(abort_v[2]),
        .done_ack(ack_v[2]), .load_en(load_v[2]), .proc_en(proc_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .state_oh(oh_v[2]), .run_cnt(rc_v[2]), .err(err_v[2])
    );

    function automatic int lc(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int pc(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge(input int i);
        if (rst_v[i]) begin
            m_mode[i] = MIdle; m_el[i] = 0; m_runs[i] = 0; m_err[i] = 1'b0;
        end else if (m_ill[i]) begin
            m_mode[i] = MIdle;
            if (DetectEn) m_err[i] = 1'b1;
        end else begin
            case (m_mode[i])
                MIdle: if (start_v[i]) begin m_mode[i] = MRun; m_el[i] = 1; end
                MRun: begin
                    if (abort_v[i]) begin
                        m_mode[i] = MIdle;
                    end else if (m_el[i] == lc(i) + pc(i)) begin
                        m_mode[i] = MDone;
                        m_runs[i] = (m_runs[i] + 1) % 65536;
                    end else begin
                        m_el[i]++;
                    end
                end
                default: if (ack_v[i]) m_mode[i] = MIdle;
            endcase
        end
        m_ill[i] = 1'b0;
    endtask

    task automatic compare(input int i);
        logic [3:0] e_oh;
        logic       e_ld, e_pr;
        e_ld = (m_mode[i] == MRun) && (m_el[i] <= lc(i));
        e_pr = (m_mode[i] == MRun) && (m_el[i] > lc(i));
        e_oh = (m_mode[i] == MIdle) ? 4'b0001 :
               (m_mode[i] == MDone) ? 4'b1000 : (e_ld ? 4'b0010 : 4'b0100);
        check_eq($sformatf("state_oh[%0d]", i), 32'(oh_v[i]), 32'(e_oh));
        check_eq($sformatf("flags[%0d]", i),
                 32'({load_v[i], proc_v[i], busy_v[i], done_v[i], err_v[i]}),
                 32'({e_ld, e_pr, e_ld | e_pr, m_mode[i] == MDone, m_err[i]}));
        check_eq($sformatf("run_cnt[%0d]", i), 32'(rc_v[i]), 32'(m_runs[i]));
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        for (int i = 0; i < 3; i++) compare(i);
    endtask

    initial begin
        rst_v = 3'b111; start_v = '0; abort_v = '0; ack_v = '0;
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = MIdle; m_el[i] = 0; m_runs[i] = 0; m_err[i] = 1'b0; m_ill[i] = 1'b0;
        end
        step();
        step();
        check_eq("timer_after_reset", 32'(dut0.u_timer.cnt_q), 32'd0);
        rst_v = '0;

        // Basic run on dut0 with late ack; Gray run on dut1 aborted in 2nd PROCESS cycle.
        for (int c = 0; c < 12; c++) begin
            start_v[0] = (c == 0); ack_v[0] = (c == 8);
            start_v[1] = (c == 0); abort_v[1] = (c == 5);
            step();
        end
        start_v = '0; abort_v = '0; ack_v = '0;

        // Ignored inputs: start during LOAD, start+abort in DONE.
        for (int c = 0; c < 12; c++) begin
            start_v[0] = (c == 0) || (c == 1) || (c == 7);
            abort_v[0] = (c == 7);
            ack_v[0]   = (c == 9);
            step();
        end
        start_v = '0; abort_v = '0; ack_v = '0;

        // Back-to-back runs with start and ack tied high, plus counter wrap.
        start_v[2] = 1'b1; ack_v[2] = 1'b1;
        repeat (8) step();
        force dut2.run_cnt_q = 16'hFFFE;
        m_runs[2] = 16'hFFFE;
        @(negedge clk);
        release dut2.run_cnt_q;
        repeat (12) step();
        start_v[2] = 1'b0; ack_v[2] = 1'b0;
        step();

        // Reset asserted mid-PROCESS.
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        repeat (3) step();
        rst_v[0] = 1'b1;
        step();
        check_eq("timer_mid_reset", 32'(dut0.u_timer.cnt_q), 32'd0);
        rst_v[0] = 1'b0;
        step();

        // Corrupt the one-hot state register; must recover to IDLE.
        force dut0.state_q = 4'b0110;
        m_ill[0] = 1'b1;
        @(negedge clk);
        release dut0.state_q;
        repeat (4) step();
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;

        // Randomized traffic on all instances.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 3; i++) begin
                start_v[i] = ($urandom_range(0, 2) == 0);
                abort_v[i] = ($urandom_range(0, 7) == 0);
                ack_v[i]   = ($urandom_range(0, 2) == 0);
                rst_v[i]   = ($urandom_range(0, 99) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
